// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared port ids, default latency and read-tracking entry type
package sram_arb_pkg;
  localparam logic PORT_SEQ = 1'b0;
  localparam logic PORT_HOST = 1'b1;
  localparam int READ_LATENCY_DEF = 2;
  typedef struct packed {
    logic valid;
    logic id;
  } trk_t;
endpackage

// File: rtl/sram_port_arbiter_rd_tracker.sv
// sram_rd_tracker: READ_LATENCY-deep {valid,id} pipeline driving sram_oe and response-valid demux
module sram_rd_tracker
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_valid,
  input  logic rd_id,
  output logic sram_oe,
  output logic p0_rsp_valid,
  output logic p1_rsp_valid
);
  trk_t [READ_LATENCY-1:0] pipe;
  trk_t in_e;
  trk_t rsp;
  always_comb begin
    in_e.valid = rd_valid;
    in_e.id = rd_id;
  end
  // The extra rsp stage lines the tag up with data leaving the wrapper
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pipe <= '0;
      rsp <= '0;
    end else begin
      pipe <= {pipe[READ_LATENCY-2:0], in_e};
      rsp <= pipe[READ_LATENCY-1];
    end
  assign sram_oe = pipe[READ_LATENCY-1].valid;
  assign p0_rsp_valid = rsp.valid & (rsp.id == PORT_SEQ);
  assign p1_rsp_valid = rsp.valid & (rsp.id == PORT_HOST);
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port valid/ready arbiter in front of the 1RW SRAM wrapper
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  logic g0, g1, xfer, cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] p0_rd_q, p1_rd_q;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    g0 = p0_valid & ~rst;
    g1 = p1_valid & ~p0_valid & ~rst;
  end
`else
  logic ptr;
  always_comb begin
    g0 = p0_valid & (~p1_valid | (ptr == PORT_SEQ)) & ~rst;
    g1 = p1_valid & (~p0_valid | (ptr == PORT_HOST)) & ~rst;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= PORT_SEQ;
    else ptr <= g0 ? PORT_HOST : g1 ? PORT_SEQ : ptr;
`endif
  always_comb begin
    xfer = g0 | g1;
    cmd_we = g1 ? p1_we : p0_we;
    cmd_addr = g1 ? p1_addr : p0_addr;
    cmd_wdata = g1 ? p1_wdata : p0_wdata;
  end
  assign p0_ready = g0;
  assign p1_ready = g1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sram_we <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
    end else begin
      sram_we <= xfer & cmd_we;
      if (xfer) begin
        sram_addr <= cmd_addr;
        sram_wdata <= cmd_wdata;
      end
    end
  sram_rd_tracker #(.READ_LATENCY(READ_LATENCY)) u_trk (
    .clk(clk),
    .rst(rst),
    .rd_valid(xfer & ~cmd_we),
    .rd_id(g1),
    .sram_oe(sram_oe),
    .p0_rsp_valid(p0_rsp_valid),
    .p1_rsp_valid(p1_rsp_valid)
  );
  // Each port keeps showing its last read data between responses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p0_rd_q <= '0;
      p1_rd_q <= '0;
    end else begin
      p0_rd_q <= p0_rsp_valid ? sram_rdata : p0_rd_q;
      p1_rd_q <= p1_rsp_valid ? sram_rdata : p1_rd_q;
    end
  assign p0_rsp_rdata = p0_rsp_valid ? sram_rdata : p0_rd_q;
  assign p1_rsp_rdata = p1_rsp_valid ? sram_rdata : p1_rd_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench with a behavioural SRAM wrapper model
module tb_sram_port_arbiter;
  logic clk = 1'b0, rst;
  logic p0_valid, p0_ready, p0_we, p0_rsp_valid;
  logic [7:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic p1_valid, p1_ready, p1_we, p1_rsp_valid;
  logic [7:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic sram_we, sram_oe;
  logic [7:0] sram_addr, sram_wdata, sram_rdata;
  logic [7:0] mem [256];
  logic [7:0] addr_q;
  int n_chk = 0, n_pass = 0;
  int widx, ridx, nrsp;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Wrapper model: address registered each cycle, data captured when oe is high
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    sram_rdata = 8'h00;
    addr_q = 8'h00;
  end
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    addr_q <= sram_addr;
    if (sram_oe) sram_rdata <= mem[addr_q];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drv(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    p0_valid = v0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, sram_we, sram_oe}, 0);
    chk(tag, {p0_rsp_rdata, p1_rsp_rdata, sram_addr, sram_wdata}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    // single port: write then read-back
    drv(1, 1, 8'h10, 8'h05, 0, 0, 0, 0);
    #1 chk("sp_wr_rdy", p0_ready, 1);
    @(negedge clk);
    chk("sp_we", {sram_we, sram_addr, sram_wdata}, {1'b1, 8'h10, 8'h05});
    drv(1, 0, 8'h10, 8'h00, 0, 0, 0, 0);
    #1 chk("sp_rd_rdy", p0_ready, 1);
    @(negedge clk);
    chk("sp_rdcmd", {sram_we, sram_oe, sram_addr}, {1'b0, 1'b0, 8'h10});
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sp_oe", {sram_oe, p0_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("sp_rsp", {p0_rsp_valid, p1_rsp_valid, sram_oe, p0_rsp_rdata}, {3'b100, 8'h05});
    @(negedge clk);
    chk("sp_hold", {p0_rsp_valid, p0_rsp_rdata}, {1'b0, 8'h05});
    // latency / oe window for a single p1 read
    drv(0, 0, 0, 0, 1, 0, 8'h10, 0);
    #1 chk("lat_rdy", {p0_ready, p1_ready}, 2'b01);
    @(negedge clk);
    chk("lat_t1", {sram_oe, p1_rsp_valid}, 2'b00);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lat_t2", {sram_oe, p1_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("lat_t3", {sram_oe, p1_rsp_valid, p0_rsp_valid, p1_rsp_rdata}, {3'b010, 8'h05});
    @(negedge clk);
    chk("lat_t4", {sram_oe, p1_rsp_valid}, 2'b00);
    // preload 0x20=AA (p0) and 0x21=BB (p1); pointer ends back on port 0
    drv(1, 1, 8'h20, 8'hAA, 0, 0, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 1, 1, 8'h21, 8'hBB);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    @(negedge clk);
    drv(1, 0, 8'h20, 0, 1, 0, 8'h21, 0);
    for (int c = 0; c < 4; c++) begin
      #1 chk("fp_both", {p0_ready, p1_ready}, 2'b10);
      @(negedge clk);
    end
    drv(0, 0, 0, 0, 1, 0, 8'h21, 0);
    #1 chk("fp_p1", {p0_ready, p1_ready}, 2'b01);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
`else
    // contention: alternating grants and responses
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 3 || c == 5) chk("ct_p0rsp", {p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata}, {2'b10, 8'hAA});
      else if (c == 4 || c == 6) chk("ct_p1rsp", {p0_rsp_valid, p1_rsp_valid, p1_rsp_rdata}, {2'b01, 8'hBB});
      else chk("ct_norsp", {p0_rsp_valid, p1_rsp_valid}, 2'b00);
      if (c < 4) drv(1, 0, 8'h20, 0, 1, 0, 8'h21, 0);
      else drv(0, 0, 0, 0, 0, 0, 0, 0);
      #1 if (c < 4) chk("ct_grant", {p0_ready, p1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
    end
    // mixed: p0 writes 0x00..0x0F, p1 reads 0x05 on every grant
    widx = 0; ridx = 0; nrsp = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (p0_rsp_valid) chk("mix_p0rsp", p0_rsp_valid, 0);
      if (p1_rsp_valid) begin
        chk("mix_rsp", p1_rsp_rdata, (nrsp < 5) ? 8'h00 : 8'h05);
        nrsp++;
      end
      drv(widx < 16, 1, widx[7:0], widx[7:0], ridx < 16, 0, 8'h05, 0);
      #1;
      if (p0_ready) widx++;
      if (p1_ready) ridx++;
    end
    chk("mix_nrsp", nrsp, 16);
    chk("mix_nwr", widx, 16);
`endif
    // reset with two reads in flight
    @(negedge clk);
    drv(1, 0, 8'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 1, 0, 8'h21, 0);
    @(negedge clk);
    rst = 1'b1;
    drv(1, 0, 8'h20, 0, 1, 0, 8'h21, 0);
    #1 chk_all_zero("rst_mid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all_zero("rst_hold");
    end
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_norsp", {p0_rsp_valid, p1_rsp_valid, sram_oe}, 3'b000);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
